// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter: takes a WIDTH-bit word over a valid/ready
// handshake and shifts it out one bit per clock, back-to-back when kept fed.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output logic             busy,
  output logic             dbg_state
);

  // Handshake: a word transfers on a rising edge where load_valid && load_ready.
  // load_ready is a function of state and counter only (never of load_valid), is
  // high in IDLE and on the last bit of a word, and is held low while reset=0.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next, sr_shift;
  logic [CW-1:0]    cnt, cnt_next;
  logic             at_last;
  logic             accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    at_last    = (cnt == LAST);
    sr_shift   = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    load_ready = 1'b0;

    case (state)
      IDLE:    load_ready = 1'b1;
      SHIFT:   load_ready = at_last;
      default: load_ready = 1'b0;
    endcase
    // Reset is asynchronous, so the ready flag must drop with it, not a clock later.
    load_ready = load_ready & reset;
    accept     = load_valid & load_ready;

    if (accept) begin
      state_next = SHIFT;
      sr_next    = par_in;
      cnt_next   = '0;
    end else if (state == SHIFT) begin
      sr_next = sr_shift;
      if (at_last) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // par_in only reaches the output through sr, so X on par_in outside an
  // accepting edge can never show up on serial_out.
  always_comb begin
    serial_valid = (state == SHIFT);
    busy         = (state == SHIFT);
    done         = (state == SHIFT) && at_last;
    serial_out   = 1'b0;
    if (state == SHIFT) begin
      serial_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    end
    dbg_state = (state == SHIFT);
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances, expected bits queued as
// {last, bit} entries when a word is handed over, popped as serial bits appear.
module tb_piso_tx;
  localparam int W = 4;

  logic         clock, reset;
  logic [W-1:0] par_in, l_par_in;
  logic         load_valid, l_load_valid;
  logic         load_ready, serial_out, serial_valid, done, busy, dbg_state;
  logic         l_load_ready, l_serial_out, l_serial_valid, l_done, l_busy, l_dbg_state;

  logic [1:0]   exp_q[$];
  logic [1:0]   l_q[$];
  logic [1:0]   e;
  int           vectors = 0;
  int           miscompares = 0;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .par_in(par_in), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out), .serial_valid(serial_valid),
    .done(done), .busy(busy), .dbg_state(dbg_state)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .par_in(l_par_in), .load_valid(l_load_valid),
    .load_ready(l_load_ready), .serial_out(l_serial_out), .serial_valid(l_serial_valid),
    .done(l_done), .busy(l_busy), .dbg_state(l_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100us");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver / model ----------------
  task automatic push_word(input logic [W-1:0] w, input bit lsb);
    for (int k = 0; k < W; k++) begin
      logic b;
      b = lsb ? w[k] : w[W-1-k];
      if (lsb) l_q.push_back({(k == W-1), b});
      else     exp_q.push_back({(k == W-1), b});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    load_valid = 1'b1;   par_in = 4'hF;
    l_load_valid = 1'b1; l_par_in = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick;
      vectors++;
      if ({load_ready, serial_out, serial_valid, done, busy, dbg_state} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_msb c%0d: rdy/out/val/done/busy/st=%b, want 000000", c,
                 {load_ready, serial_out, serial_valid, done, busy, dbg_state});
      end
      vectors++;
      if ({l_load_ready, l_serial_out, l_serial_valid, l_done, l_busy, l_dbg_state} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_lsb c%0d: rdy/out/val/done/busy/st=%b, want 000000", c,
                 {l_load_ready, l_serial_out, l_serial_valid, l_done, l_busy, l_dbg_state});
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (load_ready !== 1'b1 || l_load_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: load_ready=%b l_load_ready=%b busy=%b, want 1 1 0",
               load_ready, l_load_ready, busy);
    end
    load_valid = 1'b0;
    l_load_valid = 1'b0;
  endtask

  // Starts before the first edge after reset release, so acceptance there is covered.
  task automatic test_single;
    load_valid = 1'b1;
    par_in = 4'b1011;
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready c0: load_ready=%b, want 1", load_ready);
    end
    push_word(4'b1011, 1'b0);
    tick;
    load_valid = 1'b0;
    par_in = 'x;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (load_ready !== (c >= 4)) begin
        miscompares++;
        $display("FAIL single_ready c%0d: load_ready=%b, want %b", c, load_ready, (c >= 4));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (serial_valid !== 1'b1 || busy !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
          miscompares++;
          $display("FAIL single c%0d: val=%b busy=%b out=%b done=%b, want 1 1 %b %b",
                   c, serial_valid, busy, serial_out, done, e[0], e[1]);
        end
      end else begin
        vectors++;
        if ({serial_valid, busy, serial_out, done} !== 4'b0) begin
          miscompares++;
          $display("FAIL single_idle c%0d: val/busy/out/done=%b, want 0000", c,
                   {serial_valid, busy, serial_out, done});
        end
      end
      tick;
    end
    par_in = '0;
  endtask

  task automatic test_back_to_back;
    load_valid = 1'b1;
    par_in = 4'b1011;
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready c0: load_ready=%b, want 1", load_ready);
    end
    push_word(4'b1011, 1'b0);
    tick;
    par_in = 4'b0110;
    push_word(4'b0110, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) begin
        vectors++;
        if (load_ready !== (c == 4 || c == 8)) begin
          miscompares++;
          $display("FAIL b2b_ready c%0d: load_ready=%b, want %b", c, load_ready, (c == 4 || c == 8));
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (serial_valid !== 1'b1 || busy !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
          miscompares++;
          $display("FAIL b2b c%0d: val=%b busy=%b out=%b done=%b, want 1 1 %b %b",
                   c, serial_valid, busy, serial_out, done, e[0], e[1]);
        end
      end else begin
        vectors++;
        if ({serial_valid, busy, serial_out, done} !== 4'b0) begin
          miscompares++;
          $display("FAIL b2b_idle c%0d: val/busy/out/done=%b, want 0000", c,
                   {serial_valid, busy, serial_out, done});
        end
      end
      if (c == 8) load_valid = 1'b0;
      tick;
    end
  endtask

  // load_valid rises while bit 1 is on the wire; it must wait for the last bit.
  task automatic test_stall;
    load_valid = 1'b1;
    par_in = 4'b1100;
    push_word(4'b1100, 1'b0);
    tick;
    load_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) begin
        vectors++;
        if (load_ready !== (c == 4 || c == 8)) begin
          miscompares++;
          $display("FAIL stall_ready c%0d: load_ready=%b, want %b", c, load_ready, (c == 4 || c == 8));
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (serial_valid !== 1'b1 || busy !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
          miscompares++;
          $display("FAIL stall c%0d: val=%b busy=%b out=%b done=%b, want 1 1 %b %b",
                   c, serial_valid, busy, serial_out, done, e[0], e[1]);
        end
      end else begin
        vectors++;
        if ({serial_valid, busy, serial_out, done} !== 4'b0) begin
          miscompares++;
          $display("FAIL stall_idle c%0d: val/busy/out/done=%b, want 0000", c,
                   {serial_valid, busy, serial_out, done});
        end
      end
      if (c == 2) begin
        load_valid = 1'b1;
        par_in = 4'b0101;
        push_word(4'b0101, 1'b0);
      end
      if (c == 5) load_valid = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    load_valid = 1'b1;
    par_in = 4'b1110;
    push_word(4'b1110, 1'b0);
    tick;
    load_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      e = exp_q.pop_front();
      vectors++;
      if (serial_valid !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
        miscompares++;
        $display("FAIL rmid_pre c%0d: val=%b out=%b done=%b, want 1 %b %b",
                 c, serial_valid, serial_out, done, e[0], e[1]);
      end
      if (c < 3) tick;
    end
    reset = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if ({load_ready, serial_out, serial_valid, done, busy, dbg_state} !== 6'b0) begin
      miscompares++;
      $display("FAIL rmid_async: rdy/out/val/done/busy/st=%b, want 000000",
               {load_ready, serial_out, serial_valid, done, busy, dbg_state});
    end
    tick;
    vectors++;
    if ({done, serial_valid, busy} !== 3'b0) begin
      miscompares++;
      $display("FAIL rmid_held: done/val/busy=%b, want 000", {done, serial_valid, busy});
    end
    reset = 1'b1;
    load_valid = 1'b1;
    par_in = 4'b0001;
    #1;
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_ready: load_ready=%b, want 1", load_ready);
    end
    push_word(4'b0001, 1'b0);
    tick;
    load_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (serial_valid !== 1'b1 || busy !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
          miscompares++;
          $display("FAIL rmid_post c%0d: val=%b busy=%b out=%b done=%b, want 1 1 %b %b",
                   c, serial_valid, busy, serial_out, done, e[0], e[1]);
        end
      end else begin
        vectors++;
        if ({serial_valid, busy, serial_out, done} !== 4'b0) begin
          miscompares++;
          $display("FAIL rmid_idle c%0d: val/busy/out/done=%b, want 0000", c,
                   {serial_valid, busy, serial_out, done});
        end
      end
      tick;
    end
  endtask

  task automatic test_lsb_first;
    l_load_valid = 1'b1;
    l_par_in = 4'b1011;
    push_word(4'b1011, 1'b1);
    tick;
    l_load_valid = 1'b0;
    l_par_in = 'x;
    for (int c = 1; c <= 5; c++) begin
      if (l_q.size() > 0) begin
        e = l_q.pop_front();
        vectors++;
        if (l_serial_valid !== 1'b1 || l_busy !== 1'b1 || l_serial_out !== e[0] || l_done !== e[1]) begin
          miscompares++;
          $display("FAIL lsb c%0d: val=%b busy=%b out=%b done=%b, want 1 1 %b %b",
                   c, l_serial_valid, l_busy, l_serial_out, l_done, e[0], e[1]);
        end
      end else begin
        vectors++;
        if ({l_serial_valid, l_busy, l_serial_out, l_done} !== 4'b0) begin
          miscompares++;
          $display("FAIL lsb_idle c%0d: val/busy/out/done=%b, want 0000", c,
                   {l_serial_valid, l_busy, l_serial_out, l_done});
        end
      end
      tick;
    end
    l_par_in = '0;
  endtask

  // Random words with random gaps; ready is predicted from the queue, not read back.
  task automatic test_random;
    logic [W-1:0] w;
    bit rdy_exp;
    bit accepted;
    for (int n = 0; n < 10; n++) begin
      w = W'($urandom_range(0, 15));
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          vectors++;
          if (serial_valid !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
            miscompares++;
            $display("FAIL rand_gap w%0d: val=%b out=%b done=%b, want 1 %b %b",
                     n, serial_valid, serial_out, done, e[0], e[1]);
          end
        end else begin
          vectors++;
          if ({serial_valid, busy, serial_out, done} !== 4'b0) begin
            miscompares++;
            $display("FAIL rand_idle w%0d: val/busy/out/done=%b, want 0000", n,
                     {serial_valid, busy, serial_out, done});
          end
        end
        tick;
      end
      load_valid = 1'b1;
      par_in = w;
      accepted = 1'b0;
      for (int t = 0; t < 8 && !accepted; t++) begin
        rdy_exp = (exp_q.size() == 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          rdy_exp = e[1];
          vectors++;
          if (serial_valid !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
            miscompares++;
            $display("FAIL rand_load w%0d t%0d: val=%b out=%b done=%b, want 1 %b %b",
                     n, t, serial_valid, serial_out, done, e[0], e[1]);
          end
        end
        vectors++;
        if (load_ready !== rdy_exp) begin
          miscompares++;
          $display("FAIL rand_ready w%0d t%0d: load_ready=%b, want %b", n, t, load_ready, rdy_exp);
        end
        if (rdy_exp) begin
          push_word(w, 1'b0);
          accepted = 1'b1;
        end
        tick;
      end
      load_valid = 1'b0;
      par_in = W'($urandom_range(0, 15));
      if (!accepted) begin
        vectors++;
        miscompares++;
        $display("FAIL rand_timeout w%0d: accepted=0, want 1 within 8 cycles", n);
      end
    end
    for (int t = 0; t < 12 && exp_q.size() > 0; t++) begin
      e = exp_q.pop_front();
      vectors++;
      if (serial_valid !== 1'b1 || serial_out !== e[0] || done !== e[1]) begin
        miscompares++;
        $display("FAIL rand_drain t%0d: val=%b out=%b done=%b, want 1 %b %b",
                 t, serial_valid, serial_out, done, e[0], e[1]);
      end
      tick;
    end
    vectors++;
    if (exp_q.size() != 0 || {serial_valid, busy, done} !== 3'b0) begin
      miscompares++;
      $display("FAIL rand_end: left=%0d val/busy/done=%b, want 0 000", exp_q.size(),
               {serial_valid, busy, done});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b0;
    load_valid = 1'b0;   par_in = '0;
    l_load_valid = 1'b0; l_par_in = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_lsb_first;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
